// File: rtl/video_pack128_pkg.sv
// Shared constants and the tagged beat record for the 24-bit to 128-bit video packer.
package video_pack_pkg;

    localparam int unsigned PIX_BYTES       = 3;
    localparam int unsigned BEAT_BYTES      = 16;
    localparam int unsigned FRAME_WORDS_DEF = 172800;

    // One output beat plus its frame-position tags (130 bits).
    typedef struct packed {
        logic [127:0] data;
        logic         sof;
        logic         last;
    } beat_t;

    localparam int unsigned BEAT_W = $bits(beat_t);

endpackage

// File: rtl/video_pack128_sync_fifo.sv
// Synchronous FIFO with a registered output stage; the output register counts
// toward DEPTH, so total capacity is exactly DEPTH entries.
module sync_fifo #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned AW     = 4,
    parameter int unsigned DEPTH  = 1 << AW
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              wr_en_i,
    input  logic [DATA_W-1:0] wr_data_i,
    output logic              full_o,
    output logic              empty_o,
    input  logic              rd_en_i,
    output logic [DATA_W-1:0] rd_data_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wptr_q, rptr_q;
    logic [AW:0]       mcnt_q;
    logic [DATA_W-1:0] out_q;
    logic              out_vld_q;

    logic [AW:0] total;
    logic        rd, wr, mem_empty, to_out, push, pop;

    assign total     = mcnt_q + (AW+1)'(out_vld_q);
    assign full_o    = (total == (AW+1)'(DEPTH));
    assign empty_o   = ~out_vld_q;
    assign rd_data_o = out_q;

    // A read frees a slot in the same cycle, so write-when-full is legal alongside a read.
    assign rd        = rd_en_i & out_vld_q;
    assign wr        = wr_en_i & (~full_o | rd);
    assign mem_empty = (mcnt_q == '0);
    assign to_out    = wr & mem_empty & (~out_vld_q | rd);
    assign push      = wr & ~to_out;
    assign pop       = rd & ~mem_empty;

    // Storage array write port.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wptr_q] <= wr_data_i;
        end
    end

    // Pointers, occupancy and the registered output stage.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            mcnt_q    <= '0;
            out_q     <= '0;
            out_vld_q <= 1'b0;
        end else begin
            if (push) begin
                wptr_q <= wptr_q + AW'(1);
            end
            if (pop) begin
                rptr_q <= rptr_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   mcnt_q <= mcnt_q + (AW+1)'(1);
                2'b01:   mcnt_q <= mcnt_q - (AW+1)'(1);
                default: mcnt_q <= mcnt_q;
            endcase
            if (to_out) begin
                out_q     <= wr_data_i;
                out_vld_q <= 1'b1;
            end else if (pop) begin
                out_q <= mem_q[rptr_q];
            end else if (rd) begin
                out_vld_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/video_pack128.sv
// Packs 24-bit pixels into 128-bit little-endian beats (16 pixels -> 3 beats),
// tags frame start/end, buffers beats and counts beats lost to overflow.
module video_pack128
    import video_pack_pkg::*;
#(
    parameter int unsigned FRAME_WORDS = FRAME_WORDS_DEF,
    parameter int unsigned FIFO_DEPTH  = 16,
    parameter int unsigned FIFO_AW     = 4
) (
    input  logic         video_clk,
    input  logic         rst_n,
    input  logic         s_vsync,
    input  logic         s_hsync,
    input  logic         s_valid,
    input  logic [23:0]  s_data,
    output logic [127:0] m_data,
    output logic         m_valid,
    input  logic         m_ready,
    output logic         m_last,
    output logic         m_sof,
    output logic         frame_done,
    output logic [15:0]  ovf_cnt,
    output logic         err_short
);

    localparam int unsigned WIDX_W   = $clog2(FRAME_WORDS + 1);
    localparam int unsigned ACC_W    = 8 * (BEAT_BYTES - 1);
    localparam int unsigned MRG_W    = 8 * (BEAT_BYTES + PIX_BYTES - 1);
    localparam logic [WIDX_W-1:0] IDX_END  = WIDX_W'(FRAME_WORDS);
    localparam logic [WIDX_W-1:0] IDX_LAST = WIDX_W'(FRAME_WORDS - 1);

    logic              vsync_q, started_q;
    logic [3:0]        byte_cnt_q, byte_cnt_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [WIDX_W-1:0] word_idx_q, word_idx_d;
    beat_t             beat_q, beat_d;
    logic              beat_vld_q, beat_vld_d;
    logic              beat_over_q, beat_over_d;
    logic [15:0]       ovf_q;
    logic              err_q, done_q;

    logic              frame_start, pix_ok;
    logic [3:0]        base_cnt;
    logic [ACC_W-1:0]  base_acc;
    logic [MRG_W-1:0]  merged;
    logic [4:0]        cnt_sum;
    logic              fifo_full, fifo_empty, rd_fire, fifo_wr, drop;
    beat_t             fifo_rd;
    logic              unused_hsync;

    assign unused_hsync = s_hsync;

    // A frame start discards any partial bytes and the pixel on that cycle becomes byte 0.
    assign frame_start = s_vsync & ~vsync_q;
    assign pix_ok      = s_valid & (started_q | frame_start);
    assign base_cnt    = frame_start ? 4'd0 : byte_cnt_q;
    assign base_acc    = frame_start ? '0 : acc_q;
    assign merged      = MRG_W'(base_acc) | (MRG_W'(s_data) << {base_cnt, 3'b000});
    assign cnt_sum     = {1'b0, base_cnt} + 5'(PIX_BYTES);

    assign rd_fire = m_valid & m_ready;
    assign fifo_wr = beat_vld_q & ~beat_over_q & (~fifo_full | rd_fire);
    assign drop    = beat_vld_q & ~fifo_wr;

    // Accumulator, byte counter and beat formation with frame-position tags.
    always_comb begin
        acc_d       = base_acc;
        byte_cnt_d  = base_cnt;
        word_idx_d  = frame_start ? '0 : word_idx_q;
        beat_d      = beat_q;
        beat_vld_d  = 1'b0;
        beat_over_d = 1'b0;
        if (pix_ok) begin
            byte_cnt_d = cnt_sum[3:0];
            if (cnt_sum[4]) begin
                beat_vld_d  = 1'b1;
                beat_d.data = merged[127:0];
                beat_d.sof  = (word_idx_q == '0);
                beat_d.last = (word_idx_q == IDX_LAST);
                beat_over_d = (word_idx_q == IDX_END);
                acc_d       = ACC_W'(merged[MRG_W-1:128]);
                if (word_idx_q != IDX_END) begin
                    word_idx_d = word_idx_q + WIDX_W'(1);
                end
            end else begin
                acc_d = merged[ACC_W-1:0];
            end
        end
    end

    // Pipeline state, overflow counter, sticky short-frame flag and frame_done pulse.
    always_ff @(posedge video_clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_q     <= 1'b0;
            started_q   <= 1'b0;
            byte_cnt_q  <= '0;
            acc_q       <= '0;
            word_idx_q  <= '0;
            beat_q      <= '0;
            beat_vld_q  <= 1'b0;
            beat_over_q <= 1'b0;
            ovf_q       <= '0;
            err_q       <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            vsync_q     <= s_vsync;
            byte_cnt_q  <= byte_cnt_d;
            acc_q       <= acc_d;
            word_idx_q  <= word_idx_d;
            beat_q      <= beat_d;
            beat_vld_q  <= beat_vld_d;
            beat_over_q <= beat_over_d;
            done_q      <= rd_fire & m_last;
            if (frame_start) begin
                started_q <= 1'b1;
                if (started_q && word_idx_q != IDX_END) begin
                    err_q <= 1'b1;
                end
            end
            if (drop && ovf_q != '1) begin
                ovf_q <= ovf_q + 16'd1;
            end
        end
    end

    sync_fifo #(
        .DATA_W (BEAT_W),
        .AW     (FIFO_AW),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk_i     (video_clk),
        .rst_ni    (rst_n),
        .wr_en_i   (fifo_wr),
        .wr_data_i (beat_q),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .rd_en_i   (m_ready),
        .rd_data_o (fifo_rd)
    );

    assign m_valid    = ~fifo_empty;
    assign m_data     = fifo_rd.data;
    assign m_sof      = fifo_rd.sof;
    assign m_last     = fifo_rd.last;
    assign frame_done = done_q;
    assign ovf_cnt    = ovf_q;
    assign err_short  = err_q;

endmodule

// File: tb/tb_video_pack128.sv
// Self-checking bench for video_pack128: byte-queue reference model feeding a
// beat scoreboard, a table of frame vectors, and hand-written corner sequences.
module tb_video_pack128;
    import video_pack_pkg::*;

    localparam int unsigned FW = 48;

    logic         video_clk = 1'b0;
    logic         rst_n, s_vsync, s_hsync, s_valid, m_ready;
    logic [23:0]  s_data;
    logic [127:0] m_data;
    logic         m_valid, m_last, m_sof, frame_done, err_short;
    logic [15:0]  ovf_cnt;

    always #5 video_clk = ~video_clk;

    video_pack128 #(
        .FRAME_WORDS (FW),
        .FIFO_DEPTH  (16),
        .FIFO_AW     (4)
    ) dut (
        .video_clk  (video_clk),
        .rst_n      (rst_n),
        .s_vsync    (s_vsync),
        .s_hsync    (s_hsync),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_last     (m_last),
        .m_sof      (m_sof),
        .frame_done (frame_done),
        .ovf_cnt    (ovf_cnt),
        .err_short  (err_short)
    );

    typedef struct {
        logic [23:0]  base;
        logic [23:0]  step;
        int           npix;
        bit           same;
        int           exp_beats;
        logic         exp_err;
        logic [127:0] exp_beat0;
    } vec_t;

    vec_t         vt[5];
    int           tests = 0;
    int           fails = 0;
    beat_t        expq[$];
    logic [7:0]   bq[$];
    logic         vs_prev;
    bit           started, hold;
    int unsigned  widx;
    int           mf, ovf_exp, beats_seen, done_cnt, b0;
    logic [127:0] sof_data;

    task automatic check(input string name, input logic [129:0] act, input logic [129:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock: sample outputs on the falling edge, return just after the rising edge.
    task automatic tick();
        beat_t e;
        @(negedge video_clk);
        if (frame_done) done_cnt++;
        if (m_valid && m_ready) begin
            beats_seen++;
            if (m_sof) sof_data = m_data;
            if (expq.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_beat: got %h sof=%b last=%b expected none", m_data, m_sof, m_last);
            end else begin
                e = expq.pop_front();
                check("beat", {m_data, m_sof, m_last}, 130'(e));
            end
        end
        @(posedge video_clk);
        #1;
    endtask

    task automatic model_beat();
        logic [127:0] dat;
        beat_t b;
        for (int i = 0; i < 16; i++) dat[8*i +: 8] = bq.pop_front();
        if (widx >= FW) begin
            ovf_exp++;
        end else begin
            b.data = dat;
            b.sof  = (widx == 0);
            b.last = (widx == FW - 1);
            if (hold && mf >= 16) begin
                ovf_exp++;
            end else begin
                expq.push_back(b);
                if (hold) mf++;
            end
            widx++;
        end
    endtask

    task automatic pix(input logic vs, input logic v, input logic [23:0] d);
        s_vsync = vs;
        s_valid = v;
        s_data  = d;
        if (vs && !vs_prev) begin
            bq.delete();
            widx    = 0;
            started = 1'b1;
        end
        vs_prev = vs;
        if (v && started) begin
            bq.push_back(d[7:0]);
            bq.push_back(d[15:8]);
            bq.push_back(d[23:16]);
            if (bq.size() >= 16) model_beat();
        end
        tick();
    endtask

    task automatic idle(input int n);
        s_valid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic drain();
        int n = 0;
        s_valid = 1'b0;
        while (expq.size() != 0 && n < 400) begin
            tick();
            n++;
        end
        repeat (6) tick();
        check("drain_timeout", 130'(expq.size()), 130'(0));
    endtask

    task automatic frame(input logic [23:0] base, input logic [23:0] step, input int npix, input bit same);
        logic [23:0] d;
        pix(1'b0, 1'b0, 24'h0);
        pix(1'b0, 1'b0, 24'h0);
        if (!same) pix(1'b1, 1'b0, 24'h0);
        for (int i = 0; i < npix; i++) begin
            d = base + step * 24'(i);
            pix(1'b1, 1'b1, d);
        end
    endtask

    task automatic model_reset();
        expq.delete();
        bq.delete();
        vs_prev = 1'b0;
        started = 1'b0;
        widx    = 0;
        ovf_exp = 0;
        mf      = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{24'h000001, 24'h000001, 16, 1'b0, 3, 1'b0, 128'h06000005000004000003000002000001};
        vt[1] = '{24'hABCDEF, 24'h000000, 16, 1'b0, 3, 1'b1, 128'hEFABCDEFABCDEFABCDEFABCDEFABCDEF};
        vt[2] = '{24'h102030, 24'h010101, 16, 1'b1, 3, 1'b1, 128'h35142434132333122232112131102030};
        vt[3] = '{24'hFF0000, 24'h000001, 10, 1'b0, 1, 1'b1, 128'h05FF0004FF0003FF0002FF0001FF0000};
        vt[4] = '{24'h000100, 24'h000100, 16, 1'b1, 3, 1'b1, 128'h00000500000400000300000200000100};

        model_reset();
        hold = 1'b0;
        beats_seen = 0;
        done_cnt = 0;
        sof_data = '0;
        rst_n = 1'b0;
        s_vsync = 1'b0;
        s_hsync = 1'b0;
        s_valid = 1'b0;
        s_data = '0;
        m_ready = 1'b1;
        repeat (3) tick();
        check("rst_m_valid", 130'(m_valid), 130'(0));
        check("rst_m_data", 130'(m_data), 130'(0));
        check("rst_m_sof", 130'(m_sof), 130'(0));
        check("rst_m_last", 130'(m_last), 130'(0));
        check("rst_frame_done", 130'(frame_done), 130'(0));
        check("rst_ovf_cnt", 130'(ovf_cnt), 130'(0));
        check("rst_err_short", 130'(err_short), 130'(0));
        rst_n = 1'b1;

        // Pixels before the first frame start are ignored.
        for (int i = 0; i < 20; i++) pix(1'b0, 1'b1, 24'($urandom));
        idle(6);
        check("prestart_beats", 130'(beats_seen), 130'(0));

        // Full frame, first pixel coincident with the vsync rise, then overrun beats.
        done_cnt = 0;
        frame(24'h0A0B0C, 24'h030507, 256, 1'b1);
        drain();
        check("frame_done_cnt", 130'(done_cnt), 130'(1));
        check("full_err_short", 130'(err_short), 130'(0));
        check("full_ovf_cnt", 130'(ovf_cnt), 130'(0));
        check("full_beats", 130'(beats_seen), 130'(FW));
        for (int i = 0; i < 16; i++) pix(1'b1, 1'b1, 24'h5A5A00 + 24'(i));
        drain();
        check("overrun_ovf", 130'(ovf_cnt), 130'(ovf_exp));
        check("overrun_ovf_3", 130'(ovf_cnt), 130'(3));
        check("overrun_no_done", 130'(done_cnt), 130'(1));

        // Table of frame vectors.
        for (int v = 0; v < 5; v++) begin
            sof_data = '0;
            b0 = beats_seen;
            frame(vt[v].base, vt[v].step, vt[v].npix, vt[v].same);
            drain();
            check($sformatf("vec%0d_beats", v), 130'(beats_seen - b0), 130'(vt[v].exp_beats));
            check($sformatf("vec%0d_beat0", v), 130'(sof_data), 130'(vt[v].exp_beat0));
            check($sformatf("vec%0d_err", v), 130'(err_short), 130'(vt[v].exp_err));
        end

        // Backpressure: 30 beats against a stalled sink.
        m_ready = 1'b0;
        hold = 1'b1;
        mf = 0;
        frame(24'h400000, 24'h000003, 160, 1'b0);
        idle(5);
        check("bp_m_valid", 130'(m_valid), 130'(1));
        check("bp_ovf_model", 130'(ovf_cnt), 130'(ovf_exp));
        check("bp_ovf_17", 130'(ovf_cnt), 130'(17));
        m_ready = 1'b1;
        hold = 1'b0;
        b0 = beats_seen;
        drain();
        check("bp_beats_out", 130'(beats_seen - b0), 130'(16));

        // Asynchronous reset with five beats buffered.
        m_ready = 1'b0;
        hold = 1'b1;
        mf = 0;
        frame(24'h7F0000, 24'h000001, 27, 1'b0);
        idle(4);
        check("pre_rst_m_valid", 130'(m_valid), 130'(1));
        s_vsync = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_m_valid", 130'(m_valid), 130'(0));
        check("async_rst_ovf", 130'(ovf_cnt), 130'(0));
        check("async_rst_err", 130'(err_short), 130'(0));
        check("async_rst_m_data", 130'(m_data), 130'(0));
        model_reset();
        hold = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        m_ready = 1'b1;
        b0 = beats_seen;
        for (int i = 0; i < 20; i++) pix(1'b0, 1'b1, 24'h330000 + 24'(i));
        idle(6);
        check("post_rst_ignored", 130'(beats_seen - b0), 130'(0));
        sof_data = '0;
        frame(24'h123456, 24'h111111, 16, 1'b0);
        drain();
        check("post_rst_beats", 130'(beats_seen - b0), 130'(3));
        check("post_rst_beat0", 130'(sof_data), 130'(128'hAB56789A456789345678234567123456));
        check("post_rst_err", 130'(err_short), 130'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
